psram_arbiter: RTL and testbench
================================

# psram_arbiter

Two-port arbiter and cycle sequencer for the external asynchronous PSRAM, the Micron CellularRAM running in async mode. It sits between the PicoBlaze memory-interface path (requester 0) and a UART receive-stream buffer (requester 1). It grants the shared memory bus round-robin and generates the CE_/OE_/WE_/ADV_/UB_/LB_ strobe sequence for one 16-bit word access per grant.

## Interface
- WAIT_CYC, default 4: cycles OE_/WE_ are held low (4 × 20 ns = 80 ns at 50 MHz, meets 70 ns tAA/tWP). Legal range 1–15.
- Clk  in  1  system clock, 50 MHz, rising edge.
- Rst  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- r0_req, r1_req  in  1  access request, level; held until the matching ack.
- r0_we, r1_we  in  1  1 = write, 0 = read.
- r0_addr, r1_addr  in  23  word address.
- r0_wdata, r1_wdata  in  16  write data.
- r0_be, r1_be  in  2  byte enables, [1] upper, [0] lower.
- r0_ack, r1_ack  out  1  one-cycle completion pulse.
- r0_rdata, r1_rdata  out  16  read data; valid with ack, held until the next read for that port.
- mem_addr  out  23  PSRAM address.
- mem_dout  out  16  write data to the pad tristate.
- mem_drive  out  1  pad output enable; 1 drives mem_dout.
- mem_din  in  16  data from the pads.
- CE_, OE_, WE_, ADV_, UB_, LB_  out  1  PSRAM strobes, active low.
- CRE  out  1  configuration-register enable; constant 0.
- busy  out  1  high in any state other than IDLE.
- gnt  out  1  port of the current or last granted access.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - If any req is high, select a port, latch its we/addr/wdata/be, go to SETUP.
  - Only one requesting: grant it.
  - Both requesting: grant the port that is not gnt (round-robin).
- SETUP (1 cycle):
  - mem_addr = latched address; CE_ = 0, ADV_ = 0; UB_ = ~be[1], LB_ = ~be[0].
  - OE_ = WE_ = 1.
  - mem_drive = we.
- ACCESS (WAIT_CYC cycles, counter counts down):
  - Read: OE_ = 0. Write: WE_ = 0.
  - On the last ACCESS cycle, a read registers mem_din into the granted rdata.
- HOLD (1 cycle):
  - OE_ = WE_ = 1; CE_, ADV_, UB_/LB_, mem_addr and mem_drive unchanged. This gives address/data hold after the strobe edge.
  - The granted ack pulses high. Next state is IDLE.
- Leaving HOLD: CE_/ADV_/UB_/LB_ = 1, mem_drive = 0.
- Address, data and byte enables are latched at grant. Requester inputs may change after the grant without effect.
- be = 2'b00: the full cycle still runs with UB_ = LB_ = 1 and ack still pulses (no-op access).
- A request that is asserted in IDLE in the cycle right after its own ack starts a new access. Requesters must drop req on the edge where they sample ack.
- Reset values: CE_ = OE_ = WE_ = ADV_ = UB_ = LB_ = 1; CRE = 0; mem_addr = 0; mem_dout = 0; mem_drive = 0; acks = 0; rdata = 0; busy = 0; gnt = 1, so port 0 wins the first tie; FSM = IDLE.
- Rst asserted mid-access: the FSM returns to IDLE asynchronously and all strobes go high immediately. No ack is issued and rdata is unchanged. The requester reissues after reset.

## Timing
- req high in IDLE cycle N → SETUP at N+1 → ACCESS N+2 … N+1+WAIT_CYC → HOLD with ack at N+2+WAIT_CYC.
- Access occupancy is WAIT_CYC+3 cycles including the IDLE grant cycle: 7 cycles at the default.
- At least one IDLE cycle between accesses (bus turnaround). Continuous requesters get one grant every WAIT_CYC+3 cycles.
- Both ports requesting continuously: grants strictly alternate, so worst-case wait for either port is one access.
- OE_/WE_ low for exactly WAIT_CYC cycles. CE_ low for WAIT_CYC+2 cycles.
- Read data is sampled on the Clk edge at the end of the last ACCESS cycle, while OE_ is still low.

## Test plan
- Single read, port 0: addr 0x000123, mem_din model returns 0xBEEF → CE_ low 6 cycles, OE_ low 4 cycles, r0_ack at cycle 6 after req, r0_rdata = 0xBEEF, WE_ stays 1.
- Single write, port 1: addr 0x7FFFFF, wdata 0xA55A, be 2'b11 → WE_ low 4 cycles, mem_drive high SETUP through HOLD, mem_dout = 0xA55A, mem_addr = 0x7FFFFF, r1_ack once.
- Simultaneous requests held high for 6 accesses → gnt sequence 0, 1, 0, 1, 0, 1 out of reset; acks every 7 cycles, never both in the same cycle.
- Byte write with be = 2'b10 → UB_ = 0, LB_ = 1 for the whole access. With be = 2'b00 → both high and ack still issued.
- Rst low during the second ACCESS cycle of a read → all strobes high within the same cycle, no ack, busy = 0. After release, re-request → normal completion.
- Change r0_addr and r0_wdata on the cycle after the grant → memory sees the originally latched values.

Source files
------------

// File: rtl/psram_arbiter_if.sv
`timescale 1ns/1ps
// Requester and PSRAM pad bundle for psram_arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters-plus-pads view.
interface psram_arbiter_if;
  logic        r0_req, r1_req;
  logic        r0_we, r1_we;
  logic [22:0] r0_addr, r1_addr;
  logic [15:0] r0_wdata, r1_wdata;
  logic [1:0]  r0_be, r1_be;
  logic        r0_ack, r1_ack;
  logic [15:0] r0_rdata, r1_rdata;
  logic [22:0] mem_addr;
  logic [15:0] mem_dout;
  logic        mem_drive;
  logic [15:0] mem_din;
  logic        CE_, OE_, WE_, ADV_, UB_, LB_;
  logic        CRE;
  logic        busy;
  logic        gnt;

  modport slave (
    input  r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr,
           r0_wdata, r1_wdata, r0_be, r1_be, mem_din,
    output r0_ack, r1_ack, r0_rdata, r1_rdata, mem_addr, mem_dout,
           mem_drive, CE_, OE_, WE_, ADV_, UB_, LB_, CRE, busy, gnt
  );

  modport master (
    output r0_req, r1_req, r0_we, r1_we, r0_addr, r1_addr,
           r0_wdata, r1_wdata, r0_be, r1_be, mem_din,
    input  r0_ack, r1_ack, r0_rdata, r1_rdata, mem_addr, mem_dout,
           mem_drive, CE_, OE_, WE_, ADV_, UB_, LB_, CRE, busy, gnt
  );
endinterface

// File: rtl/psram_arbiter.sv
`timescale 1ns/1ps
// Two-port round-robin arbiter and async-mode CellularRAM strobe sequencer:
// IDLE (grant) -> SETUP -> ACCESS x WAIT_CYC -> HOLD (ack) -> IDLE.
module psram_arbiter #(
  parameter int WAIT_CYC = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  psram_arbiter_if.slave bus,
  output logic [1:0]     dbg_state
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] HOLD   = 2'd3;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  // Handshake: rN_req is a level held until rN_ack, a one-cycle pulse in HOLD.
  // The requester drops req on the edge where it samples ack; a req still high
  // in the following IDLE cycle is a new access.
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [22:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic        adv_n_q, adv_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic        drive_q, drive_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic [15:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        sel;
  logic        active;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    sel      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          // On a tie the port that did not have the last grant wins.
          sel     = (bus.r0_req && bus.r1_req) ? ~gnt_q : bus.r1_req;
          gnt_d   = sel;
          we_d    = sel ? bus.r1_we    : bus.r0_we;
          addr_d  = sel ? bus.r1_addr  : bus.r0_addr;
          wdata_d = sel ? bus.r1_wdata : bus.r0_wdata;
          be_d    = sel ? bus.r1_be    : bus.r0_be;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          if (!we_q) begin
            if (gnt_q) rdata1_d = bus.mem_din;
            else       rdata0_d = bus.mem_din;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Strobes are registered from the next state so the pads see clean edges.
    active  = (state_d != IDLE);
    ce_n_d  = ~active;
    adv_n_d = ~active;
    ub_n_d  = ~(active && be_d[1]);
    lb_n_d  = ~(active && be_d[0]);
    drive_d = active && we_d;
    oe_n_d  = ~((state_d == ACCESS) && !we_d);
    we_n_d  = ~((state_d == ACCESS) && we_d);
    ack0_d  = (state_d == HOLD) && !gnt_d;
    ack1_d  = (state_d == HOLD) && gnt_d;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      gnt_q    <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= 23'd0;
      wdata_q  <= 16'd0;
      be_q     <= 2'b00;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      adv_n_q  <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      drive_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 16'd0;
      rdata1_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      adv_n_q  <= adv_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      drive_q  <= drive_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Address and data stay on the pads after HOLD until the next grant.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_dout  = wdata_q;
  assign bus.mem_drive = drive_q;
  assign bus.CE_       = ce_n_q;
  assign bus.OE_       = oe_n_q;
  assign bus.WE_       = we_n_q;
  assign bus.ADV_      = adv_n_q;
  assign bus.UB_       = ub_n_q;
  assign bus.LB_       = lb_n_q;
  assign bus.CRE       = 1'b0;
  assign bus.r0_ack    = ack0_q;
  assign bus.r1_ack    = ack1_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt       = gnt_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_psram_arbiter.sv
`timescale 1ns/1ps
// Bench for psram_arbiter: a pad-level PSRAM model answers the strobes while a
// transaction-level memory model predicts read data, grants and timing.
module tb_psram_arbiter;
  localparam int W = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [1:0] dbg_state;

  psram_arbiter_if bus();

  psram_arbiter #(.WAIT_CYC(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #10 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] pad_mem [logic [22:0]];
  logic [15:0] ref_mem [logic [22:0]];
  logic [15:0] exp_rdata [2];
  bit          last_gnt;
  logic [15:0] pad_v;

  int          ce_cnt, oe_cnt, we_cnt, drv_cnt, ub_cnt, lb_cnt, adv_cnt;
  int          ack0_cnt, ack1_cnt, both_cnt;
  logic [22:0] oe_addr, we_addr;
  logic [15:0] we_dout;

  function automatic logic [15:0] init_word(input logic [22:0] a);
    return a[15:0] ^ 16'h3C3C;
  endfunction

  function automatic logic [15:0] pad_rd(input logic [22:0] a);
    if (pad_mem.exists(a)) return pad_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input logic [22:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  // Pad-level memory: writes lanes while WE_ is low, drives mem_din while OE_ is low.
  always @(negedge Clk) begin
    if (!bus.CE_ && !bus.WE_) begin
      pad_v = pad_rd(bus.mem_addr);
      if (!bus.UB_) pad_v[15:8] = bus.mem_dout[15:8];
      if (!bus.LB_) pad_v[7:0]  = bus.mem_dout[7:0];
      pad_mem[bus.mem_addr] = pad_v;
    end
    bus.mem_din = (!bus.CE_ && !bus.OE_) ? pad_rd(bus.mem_addr) : 16'h0000;
  end

  always @(negedge Clk) begin
    if (!bus.CE_)              ce_cnt++;
    if (!bus.ADV_)             adv_cnt++;
    if (!bus.OE_) begin        oe_cnt++; oe_addr = bus.mem_addr; end
    if (!bus.WE_) begin        we_cnt++; we_addr = bus.mem_addr; we_dout = bus.mem_dout; end
    if (bus.mem_drive)         drv_cnt++;
    if (!bus.CE_ && !bus.UB_)  ub_cnt++;
    if (!bus.CE_ && !bus.LB_)  lb_cnt++;
    if (bus.r0_ack)            ack0_cnt++;
    if (bus.r1_ack)            ack1_cnt++;
    if (bus.r0_ack && bus.r1_ack) both_cnt++;
  end

  task automatic clear_mon();
    ce_cnt = 0; oe_cnt = 0; we_cnt = 0; drv_cnt = 0; ub_cnt = 0; lb_cnt = 0;
    adv_cnt = 0; ack0_cnt = 0; ack1_cnt = 0; both_cnt = 0;
    oe_addr = '0; we_addr = '0; we_dout = '0;
  endtask

  task automatic drive_req(input bit port, input bit req, input bit we,
                           input logic [22:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be);
    if (port) begin
      bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr;
      bus.r1_wdata = wdata; bus.r1_be = be;
    end else begin
      bus.r0_req = req; bus.r0_we = we; bus.r0_addr = addr;
      bus.r0_wdata = wdata; bus.r0_be = be;
    end
  endtask

  task automatic apply_reset();
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    #1 Rst = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_gnt = 1'b1;
  endtask

  task automatic ref_write(input logic [22:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] v;
    v = ref_rd(a);
    if (be[1]) v[15:8] = d[15:8];
    if (be[0]) v[7:0]  = d[7:0];
    ref_mem[a] = v;
  endtask

  // One isolated access on one port; optionally scrambles the request inputs after the grant.
  task automatic do_access(input bit port, input bit we, input logic [22:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be, input bit scramble);
    int lat;
    bit got;
    logic [15:0] rd_exp;
    int strobe_len;
    strobe_len = W + 2;
    rd_exp = ref_rd(addr);
    clear_mon();
    drive_req(port, 1'b1, we, addr, wdata, be);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge Clk); #1;
      lat++;
      if (scramble && lat == 1) drive_req(port, 1'b1, we, ~addr, ~wdata, be);
      if ((port ? bus.r1_ack : bus.r0_ack) === 1'b1) got = 1'b1;
    end
    drive_req(port, 1'b0, 1'b0, '0, '0, '0);
    n_cmp++;
    if (!got || lat != W + 2) begin
      n_err++; $display("FAIL ack_latency port%0d: got %0d cycles, expected %0d", port, lat, W + 2);
    end
    if (we) ref_write(addr, wdata, be);
    else    exp_rdata[port] = rd_exp;
    last_gnt = port;
    n_cmp++;
    if (bus.r0_rdata !== exp_rdata[0]) begin
      n_err++; $display("FAIL r0_rdata: got %h expected %h", bus.r0_rdata, exp_rdata[0]);
    end
    n_cmp++;
    if (bus.r1_rdata !== exp_rdata[1]) begin
      n_err++; $display("FAIL r1_rdata: got %h expected %h", bus.r1_rdata, exp_rdata[1]);
    end
    @(negedge Clk); #1;
    n_cmp++;
    if (bus.gnt !== port) begin
      n_err++; $display("FAIL gnt: got %b expected %b", bus.gnt, port);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++; $display("FAIL busy_after: got %b expected 0", bus.busy);
    end
    n_cmp++;
    if (ack0_cnt != (port ? 0 : 1) || ack1_cnt != (port ? 1 : 0)) begin
      n_err++; $display("FAIL ack_count: got %0d/%0d expected port%0d once", ack0_cnt, ack1_cnt, port);
    end
    n_cmp++;
    if (ce_cnt != strobe_len || adv_cnt != strobe_len) begin
      n_err++; $display("FAIL ce_adv_len: got %0d/%0d expected %0d", ce_cnt, adv_cnt, strobe_len);
    end
    n_cmp++;
    if (oe_cnt != (we ? 0 : W) || we_cnt != (we ? W : 0)) begin
      n_err++; $display("FAIL oe_we_len: got oe %0d we %0d, expected oe %0d we %0d",
                        oe_cnt, we_cnt, we ? 0 : W, we ? W : 0);
    end
    n_cmp++;
    if (drv_cnt != (we ? strobe_len : 0)) begin
      n_err++; $display("FAIL drive_len: got %0d expected %0d", drv_cnt, we ? strobe_len : 0);
    end
    n_cmp++;
    if (ub_cnt != (be[1] ? strobe_len : 0) || lb_cnt != (be[0] ? strobe_len : 0)) begin
      n_err++; $display("FAIL byte_lanes: got ub %0d lb %0d for be %b", ub_cnt, lb_cnt, be);
    end
    n_cmp++;
    if (we ? (we_addr !== addr || we_dout !== wdata) : (oe_addr !== addr)) begin
      n_err++; $display("FAIL pad_addr_data: got addr %h dout %h/%h expected addr %h data %h",
                        we ? we_addr : oe_addr, we_dout, bus.mem_dout, addr, wdata);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge Clk); #1;
    n_cmp++;
    if ({bus.CE_, bus.OE_, bus.WE_, bus.ADV_, bus.UB_, bus.LB_} !== 6'b111111) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 111111",
                        {bus.CE_, bus.OE_, bus.WE_, bus.ADV_, bus.UB_, bus.LB_});
    end
    n_cmp++;
    if ({bus.CRE, bus.mem_drive, bus.r0_ack, bus.r1_ack, bus.busy, bus.gnt} !== 6'b000001) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 000001",
                        {bus.CRE, bus.mem_drive, bus.r0_ack, bus.r1_ack, bus.busy, bus.gnt});
    end
    n_cmp++;
    if (bus.mem_addr !== 23'd0 || bus.mem_dout !== 16'd0 ||
        bus.r0_rdata !== 16'd0 || bus.r1_rdata !== 16'd0) begin
      n_err++; $display("FAIL reset_data: got addr %h dout %h rd0 %h rd1 %h expected all 0",
                        bus.mem_addr, bus.mem_dout, bus.r0_rdata, bus.r1_rdata);
    end
  endtask

  task automatic test_single_read();
    pad_mem[23'h000123] = 16'hBEEF;
    ref_mem[23'h000123] = 16'hBEEF;
    do_access(1'b0, 1'b0, 23'h000123, 16'h0000, 2'b11, 1'b0);
  endtask

  task automatic test_single_write();
    do_access(1'b1, 1'b1, 23'h7FFFFF, 16'hA55A, 2'b11, 1'b0);
    do_access(1'b0, 1'b0, 23'h7FFFFF, 16'h0000, 2'b11, 1'b0);
  endtask

  task automatic test_byte_enables();
    do_access(1'b0, 1'b1, 23'h000040, 16'h1234, 2'b11, 1'b0);
    do_access(1'b0, 1'b1, 23'h000040, 16'hABCD, 2'b10, 1'b0);
    do_access(1'b1, 1'b1, 23'h000040, 16'hFFFF, 2'b00, 1'b0);
    do_access(1'b1, 1'b0, 23'h000040, 16'h0000, 2'b11, 1'b0);
  endtask

  task automatic test_round_robin();
    logic [22:0] a0, a1;
    int acks, cyc, prev;
    bit exp_port;
    a0 = 23'h000200;
    a1 = 23'h000201;
    pad_mem[a0] = 16'($urandom); ref_mem[a0] = pad_mem[a0];
    pad_mem[a1] = 16'($urandom); ref_mem[a1] = pad_mem[a1];
    apply_reset();
    clear_mon();
    drive_req(1'b0, 1'b1, 1'b0, a0, '0, 2'b11);
    drive_req(1'b1, 1'b1, 1'b0, a1, '0, 2'b11);
    acks = 0; cyc = 0; prev = -1;
    while (acks < 6 && cyc < 100) begin
      @(negedge Clk); #1;
      cyc++;
      if (bus.r0_ack === 1'b1 || bus.r1_ack === 1'b1) begin
        exp_port = ~last_gnt;
        last_gnt = exp_port;
        if (acks == 5) begin
          drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
          drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        end
        n_cmp++;
        if (bus.r1_ack !== exp_port || bus.r0_ack !== ~exp_port) begin
          n_err++; $display("FAIL rr_ack_port: got r0 %b r1 %b expected port%0d",
                            bus.r0_ack, bus.r1_ack, exp_port);
        end
        n_cmp++;
        if ((exp_port ? bus.r1_rdata : bus.r0_rdata) !== ref_rd(exp_port ? a1 : a0)) begin
          n_err++; $display("FAIL rr_rdata: got %h expected %h",
                            exp_port ? bus.r1_rdata : bus.r0_rdata, ref_rd(exp_port ? a1 : a0));
        end
        n_cmp++;
        if (cyc - prev != ((prev < 0) ? W + 2 + 1 : W + 3)) begin
          n_err++; $display("FAIL rr_spacing: got %0d cycles expected %0d",
                            cyc - prev, (prev < 0) ? W + 3 : W + 3);
        end
        prev = cyc;
        acks++;
      end
    end
    @(negedge Clk); #1;
    exp_rdata[0] = ref_rd(a0);
    exp_rdata[1] = ref_rd(a1);
    n_cmp++;
    if (acks != 6 || both_cnt != 0 || ack0_cnt != 3 || ack1_cnt != 3) begin
      n_err++; $display("FAIL rr_totals: got %0d acks (%0d/%0d, %0d both) expected 6 (3/3, 0 both)",
                        acks, ack0_cnt, ack1_cnt, both_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    clear_mon();
    drive_req(1'b0, 1'b1, 1'b0, 23'h000123, '0, 2'b11);
    lat = 0;
    while (lat < 3) begin
      @(negedge Clk); #1;
      lat++;
    end
    Rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.CE_, bus.OE_, bus.WE_, bus.ADV_, bus.UB_, bus.LB_} !== 6'b111111) begin
      n_err++; $display("FAIL midreset_strobes: got %b expected 111111",
                        {bus.CE_, bus.OE_, bus.WE_, bus.ADV_, bus.UB_, bus.LB_});
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.r0_ack !== 1'b0 || bus.mem_drive !== 1'b0) begin
      n_err++; $display("FAIL midreset_ctrl: got busy %b ack %b drive %b expected 0 0 0",
                        bus.busy, bus.r0_ack, bus.mem_drive);
    end
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge Clk); #1;
    Rst = 1'b1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    last_gnt = 1'b1;
    @(negedge Clk); #1;
    n_cmp++;
    if (ack0_cnt != 0 || bus.r0_rdata !== 16'd0) begin
      n_err++; $display("FAIL midreset_noack: got %0d acks rdata %h expected 0 acks rdata 0000",
                        ack0_cnt, bus.r0_rdata);
    end
    do_access(1'b0, 1'b0, 23'h000123, 16'h0000, 2'b11, 1'b0);
  endtask

  task automatic test_latched_inputs();
    do_access(1'b0, 1'b1, 23'h001234, 16'h1357, 2'b11, 1'b1);
    do_access(1'b1, 1'b0, 23'h001234, 16'h0000, 2'b11, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                23'h000400 | 23'($urandom_range(0, 7)), 16'($urandom),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    bus.mem_din = '0;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
    clear_mon();
    test_reset();
    test_single_read();
    test_single_write();
    test_byte_enables();
    test_round_robin();
    test_reset_mid();
    test_latched_inputs();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
